// File: rtl/cart_pkg.sv
// rtl/cart_pkg.sv - shared types and constants for the cartridge bus responder
package cart_pkg;

  localparam int AD_W = 16;
  localparam logic [AD_W-1:0] FILL_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    READY,
    DRIVE
  } cart_state_t;

endpackage

// File: rtl/cart_sync.sv
// rtl/cart_sync.sv - N-bit multi-stage synchronizer with registered edge pulses
module cart_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] chain [STAGES];

  // Edge pulses line up with q: they compare the value about to appear on q
  // against the value q holds now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      rise <= chain[STAGES-2] & ~chain[STAGES-1];
      fall <= ~chain[STAGES-2] & chain[STAGES-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cart_responder.sv
// rtl/cart_responder.sv - cartridge-side responder serving RD pulses from a prefetching memory port
module cart_responder
  import cart_pkg::*;
#(
  parameter int              SYNC_STAGES = 2,
  parameter logic [AD_W-1:0] FILL_WORD   = FILL_WORD_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CS,
  input  logic            RD,
  input  logic            WR,
  input  logic [AD_W-1:0] AD_IN,
  output logic [AD_W-1:0] AD_OUT,
  output logic            AD_OE,
  output logic            MEM_REQ,
  output logic [AD_W-1:0] MEM_ADDR,
  input  logic            MEM_VALID,
  input  logic [AD_W-1:0] MEM_DATA,
  output logic            UNDERRUN,
  output logic [15:0]     READ_COUNT
);

  logic [2:0]      strb_q, strb_rise, strb_fall;
  logic [AD_W-1:0] ad_q, ad_rise, ad_fall;
  logic            cs_fall, cs_rise, rd_fall, rd_rise;
  logic            unused_sync;

  cart_state_t     state;
  logic [AD_W-1:0] addr;
  logic [AD_W-1:0] buf_data;
  logic            buf_valid;
  logic            und;
  logic            fetch_issued;
  logic            req_live;

  cart_sync #(.W(3), .STAGES(SYNC_STAGES)) u_strb_sync (
    .clk  (CLK),
    .rst  (RST),
    .d    ({CS, RD, WR}),
    .q    (strb_q),
    .rise (strb_rise),
    .fall (strb_fall)
  );

  cart_sync #(.W(AD_W), .STAGES(SYNC_STAGES)) u_ad_sync (
    .clk  (CLK),
    .rst  (RST),
    .d    (AD_IN),
    .q    (ad_q),
    .rise (ad_rise),
    .fall (ad_fall)
  );

  assign cs_fall     = strb_fall[2];
  assign cs_rise     = strb_rise[2];
  assign rd_fall     = strb_fall[1];
  assign rd_rise     = strb_rise[1];
  assign unused_sync = ^{strb_q, strb_rise[0], strb_fall[0], ad_rise, ad_fall};

  // req_live marks the outstanding fetch as belonging to the current address;
  // a fetch orphaned by CS rise or an underrun still completes but is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      addr         <= '0;
      buf_data     <= '0;
      buf_valid    <= 1'b0;
      und          <= 1'b0;
      fetch_issued <= 1'b0;
      req_live     <= 1'b0;
      MEM_REQ      <= 1'b0;
      MEM_ADDR     <= '0;
      AD_OE        <= 1'b0;
      AD_OUT       <= FILL_WORD;
      UNDERRUN     <= 1'b0;
      READ_COUNT   <= '0;
    end else begin
      if (MEM_REQ && MEM_VALID) begin
        MEM_REQ  <= 1'b0;
        req_live <= 1'b0;
      end

      if (cs_rise) begin
        state     <= IDLE;
        AD_OE     <= 1'b0;
        und       <= 1'b0;
        buf_valid <= 1'b0;
        req_live  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              addr         <= ad_q;
              state        <= FETCH;
              fetch_issued <= 1'b0;
              if (rd_fall) begin
                AD_OE    <= 1'b1;
                AD_OUT   <= FILL_WORD;
                UNDERRUN <= 1'b1;
                und      <= 1'b1;
              end
            end
          end
          FETCH: begin
            if (!fetch_issued && !MEM_REQ) begin
              MEM_REQ      <= 1'b1;
              MEM_ADDR     <= addr;
              fetch_issued <= 1'b1;
              req_live     <= 1'b1;
            end
            if (und) begin
              if (rd_rise) begin
                AD_OE        <= 1'b0;
                und          <= 1'b0;
                addr         <= addr + 16'd1;
                READ_COUNT   <= READ_COUNT + 16'd1;
                fetch_issued <= 1'b0;
                req_live     <= 1'b0;
              end
            end else if (rd_fall) begin
              AD_OE    <= 1'b1;
              AD_OUT   <= FILL_WORD;
              UNDERRUN <= 1'b1;
              und      <= 1'b1;
            end else if (MEM_REQ && MEM_VALID && req_live) begin
              buf_data  <= MEM_DATA;
              buf_valid <= 1'b1;
              state     <= READY;
            end
          end
          READY: begin
            if (rd_fall && buf_valid) begin
              AD_OE  <= 1'b1;
              AD_OUT <= buf_data;
              state  <= DRIVE;
            end
          end
          DRIVE: begin
            if (rd_rise) begin
              AD_OE        <= 1'b0;
              buf_valid    <= 1'b0;
              addr         <= addr + 16'd1;
              READ_COUNT   <= READ_COUNT + 16'd1;
              fetch_issued <= 1'b0;
              state        <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
